// File: rtl/mux_scan_reg_if.sv
// Bus bundle for mux_scan_reg: packed channel inputs, select/mode controls,
// and the registered word, index and wrap pulse coming back.
interface mux_scan_reg_if #(
    parameter int W = 8,
    parameter int N = 8,
    parameter int S = 3
);
    logic [N*W-1:0] data;
    logic [S-1:0]   ctrl;
    logic           mode;
    logic           hold;
    logic [W-1:0]   f;
    logic [S-1:0]   sel_out;
    logic           wrap;

    modport master (
        output data, ctrl, mode, hold,
        input  f, sel_out, wrap
    );

    modport slave (
        input  data, ctrl, mode, hold,
        output f, sel_out, wrap
    );
endinterface

// File: rtl/mux_scan_reg.sv
// Registered N:1 word multiplexer. MANUAL mode forwards the channel named by
// ctrl; SCAN mode walks every channel round-robin, dwelling DWELL cycles on
// each, with hold freezing the walk.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   MANUAL | output follows ctrl; scan pointer and dwell counter parked at 0
//   SCAN   | output follows the scan pointer, which advances every DWELL edges
module mux_scan_reg #(
    parameter int W     = 8,
    parameter int N     = 8,
    parameter int S     = 3,
    parameter int DWELL = 1
) (
    input  logic           clk,
    input  logic           rst,
    mux_scan_reg_if.slave  bus
);
    localparam int DW_W = $clog2(DWELL) + 1;
    localparam logic [DW_W-1:0] DCNT_LAST = DW_W'(DWELL - 1);
    localparam logic [S-1:0]    PTR_LAST  = S'(N - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    state_t          state;
    logic [S-1:0]    ptr;
    logic [DW_W-1:0] dcnt;
    logic [W-1:0]    f_q;
    logic [S-1:0]    sel_q;
    logic            wrap_q;

    logic [S-1:0]    cur_ptr;
    logic [DW_W-1:0] cur_dcnt;
    logic [W-1:0]    man_word;
    logic [W-1:0]    scan_word;

    // Entering SCAN always starts from channel 0 with a fresh dwell count,
    // whatever the parked registers hold.
    always_comb begin
        cur_ptr  = (state == SCAN) ? ptr  : '0;
        cur_dcnt = (state == SCAN) ? dcnt : '0;
    end

    // Word lookup by compare loop so indices >= N never touch the data bus;
    // an out-of-range ctrl yields zero.
    always_comb begin
        man_word  = '0;
        scan_word = '0;
        for (int k = 0; k < N; k++) begin
            if (bus.ctrl == S'(k)) man_word  = bus.data[k*W +: W];
            if (cur_ptr  == S'(k)) scan_word = bus.data[k*W +: W];
        end
    end

    // Mode FSM, scan pointer/dwell counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= MANUAL;
            ptr    <= '0;
            dcnt   <= '0;
            f_q    <= '0;
            sel_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            state  <= bus.mode ? SCAN : MANUAL;
            wrap_q <= 1'b0;
            if (!bus.mode) begin
                f_q   <= man_word;
                sel_q <= bus.ctrl;
                ptr   <= '0;
                dcnt  <= '0;
            end else begin
                f_q   <= scan_word;
                sel_q <= cur_ptr;
                if (bus.hold) begin
                    ptr  <= cur_ptr;
                    dcnt <= cur_dcnt;
                end else if (cur_dcnt == DCNT_LAST) begin
                    dcnt <= '0;
                    if (cur_ptr == PTR_LAST) begin
                        ptr    <= '0;
                        wrap_q <= 1'b1;
                    end else begin
                        ptr <= cur_ptr + 1'b1;
                    end
                end else begin
                    ptr  <= cur_ptr;
                    dcnt <= cur_dcnt + 1'b1;
                end
            end
        end
    end

    assign bus.f       = f_q;
    assign bus.sel_out = sel_q;
    assign bus.wrap    = wrap_q;
endmodule
